// File: rtl/priority_request_latch.sv
// ---------------------------------------------------------------------------
// priority_request_latch
//
// Request-capture stage that sits in front of a 4-line priority encoder.
// Single-cycle request pulses on four channels are latched into a sticky
// pending vector that feeds the encoder. The encoder's winning channel is
// captured and offered to a consumer over a valid/ready handshake; a
// channel's pending bit is cleared only when the consumer accepts it.
//
// Optional feature macro: PRL_DROP_CNT_EN
//   defined   -> o_drop_cnt counts cycles in which a request hit a channel
//                that was already pending (saturating, cleared only by reset)
//   undefined -> no counter logic, o_drop_cnt tied to 0
//
// Parameters:
//   CNT_W        width of the drop counter
//
// Ports:
//   i_clk        clock, all logic on the rising edge
//   i_rst_n      synchronous active-low reset
//   i_req[3:0]   request pulses, bit n requests channel n
//   i_flush      drop all pending requests and any open offer
//   o_pend[3:0]  registered pending vector, drives encoder i_code
//   i_enc_code   encoder o_code (combinational from o_pend)
//   i_enc_valid  encoder o_valid
//   o_valid      grant offer valid
//   o_code       granted channel index, stable while o_valid is high
//   i_ready      consumer accepts the offer when o_valid & i_ready
//   o_drop_cnt   saturating count of lost requests
// ---------------------------------------------------------------------------
module priority_request_latch #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [3:0]       i_req,
    input  logic             i_flush,
    output logic [3:0]       o_pend,
    input  logic [1:0]       i_enc_code,
    input  logic             i_enc_valid,
    output logic             o_valid,
    output logic [1:0]       o_code,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_drop_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;

    state_e     state_q;
    logic [3:0] pend_q;
    logic [3:0] pend_d;
    logic [3:0] clr;
    logic       valid_q;
    logic [1:0] code_q;
    logic       accept;

    assign accept = valid_q & i_ready;

    // Pending next state: the accepted channel is cleared, new requests are
    // OR-ed in afterwards so a same-cycle set wins over the clear.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        clr = '0;
        if (accept) begin
            clr[code_q] = 1'b1;
        end
        pend_d = (pend_q & ~clr) | i_req;
        if (i_flush) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignment; reset is sampled on the clock edge.
        if (!i_rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Offer FSM. The captured code is held for the whole offer: later changes
    // on the encoder output never preempt an offer already on the wire.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            code_q  <= 2'b00;
        end else if (i_flush) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_enc_valid) begin
                        code_q  <= i_enc_code;
                        valid_q <= 1'b1;
                        state_q <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_pend  = pend_q;
    assign o_valid = valid_q;
    assign o_code  = code_q;

`ifdef PRL_DROP_CNT_EN
    logic [CNT_W-1:0] drop_q;
    logic             collide;

    // A request is lost when it lands on a bit that is already pending and
    // not being released this cycle; several such bits count once.
    assign collide = |(i_req & pend_q & ~clr);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            drop_q <= '0;
        end else if (!i_flush && collide && (drop_q != '1)) begin
            drop_q <= drop_q + CNT_W'(1);
        end
    end

    assign o_drop_cnt = drop_q;
`else
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_priority_request_latch.sv
// ---------------------------------------------------------------------------
// tb_priority_request_latch
//
// Self-checking bench for priority_request_latch. A behavioural priority
// encoder (channel 0 highest) closes the loop from o_pend back to the DUT.
// Every cycle is compared against a reference model that tracks pending
// channels, the open offer and the drop count; a directed table, a few
// hand-written corner sequences and a randomized phase drive the DUT.
// Honours PRL_DROP_CNT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_priority_request_latch;

    localparam int CNT_W = 2;
`ifdef PRL_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic             i_clk;
    logic             i_rst_n;
    logic [3:0]       i_req;
    logic             i_flush;
    logic [3:0]       o_pend;
    logic [1:0]       i_enc_code;
    logic             i_enc_valid;
    logic             o_valid;
    logic [1:0]       o_code;
    logic             i_ready;
    logic [CNT_W-1:0] o_drop_cnt;

    int checks = 0;
    int errors = 0;

    priority_request_latch #(.CNT_W(CNT_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req       (i_req),
        .i_flush     (i_flush),
        .o_pend      (o_pend),
        .i_enc_code  (i_enc_code),
        .i_enc_valid (i_enc_valid),
        .o_valid     (o_valid),
        .o_code      (o_code),
        .i_ready     (i_ready),
        .o_drop_cnt  (o_drop_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Encoder stand-in: lowest-numbered pending channel wins.
    always_comb begin
        i_enc_valid = |o_pend;
        i_enc_code  = 2'b00;
        for (int i = 3; i >= 0; i--) begin
            if (o_pend[i]) i_enc_code = 2'(i);
        end
    end

    // ---------------- reference model ----------------
    bit m_pend [4];
    bit m_offer;
    int m_ch;
    int m_drop;

    function automatic void model_step(bit rst_n, bit [3:0] req, bit flush, bit ready);
        int  took;
        int  first;
        bit  lost;
        if (!rst_n) begin
            foreach (m_pend[n]) m_pend[n] = 1'b0;
            m_offer = 1'b0;
            m_ch    = 0;
            m_drop  = 0;
            return;
        end
        if (flush) begin
            foreach (m_pend[n]) m_pend[n] = 1'b0;
            m_offer = 1'b0;
            return;
        end
        took  = (m_offer && ready) ? m_ch : -1;
        first = -1;
        foreach (m_pend[n]) if (m_pend[n] && first < 0) first = n;
        lost = 1'b0;
        foreach (m_pend[n]) if (req[n] && m_pend[n] && n != took) lost = 1'b1;
        foreach (m_pend[n]) m_pend[n] = req[n] || (m_pend[n] && n != took);
        if (DROP_EN && lost && m_drop < (1 << CNT_W) - 1) m_drop++;
        if (m_offer) begin
            if (ready) m_offer = 1'b0;
        end else if (first >= 0) begin
            m_offer = 1'b1;
            m_ch    = first;
        end
    endfunction

    function automatic bit [3:0] model_pend_vec();
        bit [3:0] v;
        foreach (m_pend[n]) v[n] = m_pend[n];
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Apply one cycle of inputs, advance model and DUT, compare against model.
    task automatic tick(input bit rst_n, input bit [3:0] req, input bit flush, input bit ready);
        i_rst_n = rst_n;
        i_req   = req;
        i_flush = flush;
        i_ready = ready;
        model_step(rst_n, req, flush, ready);
        @(posedge i_clk);
        #1;
        check("model_pend",  int'(o_pend),     int'(model_pend_vec()));
        check("model_valid", int'(o_valid),    int'(m_offer));
        check("model_code",  int'(o_code),     m_ch);
        check("model_drop",  int'(o_drop_cnt), m_drop);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit       rst_n;
        bit [3:0] req;
        bit       flush;
        bit       ready;
        bit [3:0] pend;
        bit       valid;
        bit [1:0] code;
    } vec_t;

    vec_t tbl [17];

    initial begin
        // Latency / priority: 1010 pulse, ready tied high.
        tbl[0]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{1'b1, 4'b1010, 1'b0, 1'b1, 4'b1010, 1'b0, 2'd0};
        tbl[2]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b1010, 1'b1, 2'd1};
        tbl[3]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b0, 2'd1};
        tbl[4]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[5]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3};
        tbl[6]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3};
        tbl[7]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3};
        // Backpressure: ch3 held, ch0 arrives later, no preemption.
        tbl[8]  = '{1'b1, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0, 2'd3};
        tbl[9]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3};
        tbl[10] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3};
        tbl[11] = '{1'b1, 4'b0001, 1'b0, 1'b0, 4'b1001, 1'b1, 2'd3};
        tbl[12] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b1001, 1'b1, 2'd3};
        tbl[13] = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd3};
        tbl[14] = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[15] = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[16] = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};

        i_rst_n = 1'b0;
        i_req   = 4'b0000;
        i_flush = 1'b0;
        i_ready = 1'b0;
        m_offer = 1'b0;
        m_ch    = 0;
        m_drop  = 0;
        foreach (m_pend[n]) m_pend[n] = 1'b0;
        @(negedge i_clk);

        for (int r = 0; r < 17; r++) begin
            tick(tbl[r].rst_n, tbl[r].req, tbl[r].flush, tbl[r].ready);
            check($sformatf("tbl%0d_pend", r),  int'(o_pend),     int'(tbl[r].pend));
            check($sformatf("tbl%0d_valid", r), int'(o_valid),    int'(tbl[r].valid));
            check($sformatf("tbl%0d_code", r),  int'(o_code),     int'(tbl[r].code));
            check($sformatf("tbl%0d_drop", r),  int'(o_drop_cnt), 0);
        end

        // Reset in the middle of an offer on ch2.
        tick(1'b1, 4'b0100, 1'b0, 1'b0);
        tick(1'b1, 4'b0000, 1'b0, 1'b0);
        check("rst_pre_valid", int'(o_valid), 1);
        check("rst_pre_code",  int'(o_code),  2);
        tick(1'b0, 4'b0000, 1'b0, 1'b0);
        check("rst_pend",  int'(o_pend),     0);
        check("rst_valid", int'(o_valid),    0);
        check("rst_code",  int'(o_code),     0);
        check("rst_drop",  int'(o_drop_cnt), 0);

        // Set wins over clear on the accepted channel.
        tick(1'b1, 4'b0010, 1'b0, 1'b0);
        tick(1'b1, 4'b0000, 1'b0, 1'b0);
        check("soc_offer_code", int'(o_code), 1);
        tick(1'b1, 4'b0010, 1'b0, 1'b1);
        check("soc_pend_kept", int'(o_pend[1]),  1);
        check("soc_valid_low", int'(o_valid),    0);
        check("soc_drop",      int'(o_drop_cnt), 0);
        tick(1'b1, 4'b0000, 1'b0, 1'b1);
        check("soc_reoffer_valid", int'(o_valid), 1);
        check("soc_reoffer_code",  int'(o_code),  1);
        tick(1'b1, 4'b0000, 1'b0, 1'b1);
        check("soc_cleared", int'(o_pend), 0);

        // Drop counter saturation: ch1 held pending, pulsed five more times.
        tick(1'b0, 4'b0000, 1'b0, 1'b0);
        tick(1'b1, 4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 4'b0010, 1'b0, 1'b0);
            check($sformatf("drop_%0d", i), int'(o_drop_cnt),
                  DROP_EN ? ((i + 1 > 3) ? 3 : i + 1) : 0);
        end

        // Flush with everything pending and an open offer; drops survive.
        tick(1'b1, 4'b1111, 1'b0, 1'b0);
        check("fl_pre_pend",  int'(o_pend),  15);
        check("fl_pre_valid", int'(o_valid), 1);
        tick(1'b1, 4'b0001, 1'b1, 1'b0);
        check("fl_pend",  int'(o_pend),     0);
        check("fl_valid", int'(o_valid),    0);
        check("fl_drop",  int'(o_drop_cnt), DROP_EN ? 3 : 0);

        // Randomized traffic against the model.
        tick(1'b0, 4'b0000, 1'b0, 1'b0);
        for (int c = 0; c < 600; c++) begin
            bit       rr;
            bit       ff;
            bit       rd;
            bit [3:0] rq;
            rr = ($urandom_range(0, 79) != 0);
            ff = ($urandom_range(0, 15) == 0);
            rd = ($urandom_range(0, 2) != 0);
            rq = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            tick(rr, rq, ff, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
